// File: rtl/status_reporter.sv
// rtl/status_reporter.sv - telemetry packet transmitter for FIFO event counters
// Snapshots event counters on a tick or request and streams an 8-byte status packet.
module status_reporter #(
  parameter int unsigned PERIOD_CLKS = 126000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req,
  input  logic       rx_beat,
  input  logic       rx_drop,
  input  logic       underrun,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  output logic [7:0] tx_data_si,
  output logic       tx_valid_si,
  input  logic       tx_ready_si,
  output logic       busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [26:0] TIMER_LAST = (PERIOD_CLKS == 0) ? 27'd0 : 27'(PERIOD_CLKS - 1);

  state_t      state;
  logic [26:0] timer;
  logic [2:0]  idx;
  logic [15:0] rx_cnt;
  logic [7:0]  ovf_cnt;
  logic [7:0]  udf_cnt;
  logic [7:0]  seq;
  logic        pending;
  logic        missed;

  logic [7:0]  snap_seq;
  logic [7:0]  snap_flags;
  logic [15:0] snap_rx;
  logic [7:0]  snap_ovf;
  logic [7:0]  snap_udf;
  logic [7:0]  snap_chk;

  logic        tick;
  logic        trigger;
  logic        launch;
  logic        xfer;
  logic [7:0]  cur_flags;
  logic [7:0]  cur_chk;
  logic [7:0]  next_byte;

  assign tick      = (PERIOD_CLKS != 0) && enable && (timer == TIMER_LAST);
  assign trigger   = enable & (req | tick);
  assign launch    = trigger | (pending & enable);
  assign xfer      = tx_valid_si & tx_ready_si;
  assign busy      = (state == SEND);
  assign cur_flags = {5'b0, missed, fifo_full, fifo_empty};
  assign cur_chk   = seq ^ cur_flags ^ rx_cnt[15:8] ^ rx_cnt[7:0] ^ ovf_cnt ^ udf_cnt;

  // Byte that follows the one currently presented at position idx.
  always_comb begin
    next_byte = 8'h00;
    case (idx)
      3'd0:    next_byte = snap_seq;
      3'd1:    next_byte = snap_flags;
      3'd2:    next_byte = snap_rx[15:8];
      3'd3:    next_byte = snap_rx[7:0];
      3'd4:    next_byte = snap_ovf;
      3'd5:    next_byte = snap_udf;
      3'd6:    next_byte = snap_chk;
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      rx_cnt      <= '0;
      ovf_cnt     <= '0;
      udf_cnt     <= '0;
      seq         <= '0;
      pending     <= 1'b0;
      missed      <= 1'b0;
      snap_seq    <= '0;
      snap_flags  <= '0;
      snap_rx     <= '0;
      snap_ovf    <= '0;
      snap_udf    <= '0;
      snap_chk    <= '0;
      tx_data_si  <= '0;
      tx_valid_si <= 1'b0;
    end else begin
      if (!enable || tick || PERIOD_CLKS == 0)
        timer <= '0;
      else
        timer <= timer + 27'd1;

      rx_cnt <= rx_cnt + 16'(rx_beat);

      if (state == IDLE && launch) begin
        // Events coinciding with the snapshot belong to the new period.
        ovf_cnt <= {7'b0, rx_drop};
        udf_cnt <= {7'b0, underrun};
      end else begin
        if (rx_drop && ovf_cnt != 8'hFF)
          ovf_cnt <= ovf_cnt + 8'd1;
        if (underrun && udf_cnt != 8'hFF)
          udf_cnt <= udf_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            snap_seq    <= seq;
            snap_flags  <= cur_flags;
            snap_rx     <= rx_cnt;
            snap_ovf    <= ovf_cnt;
            snap_udf    <= udf_cnt;
            snap_chk    <= cur_chk;
            pending     <= 1'b0;
            // The miss is reported in this packet, so it is no longer outstanding.
            missed      <= 1'b0;
            idx         <= '0;
            tx_data_si  <= SYNC_BYTE;
            tx_valid_si <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (trigger) begin
            if (!pending)
              pending <= 1'b1;
            else
              missed <= 1'b1;
          end
          if (xfer) begin
            if (idx == 3'd7) begin
              tx_valid_si <= 1'b0;
              seq         <= seq + 8'd1;
              state       <= IDLE;
            end else begin
              idx        <= idx + 3'd1;
              tx_data_si <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_status_reporter.sv
// tb/tb_status_reporter.sv - directed self-checking bench for status_reporter
// Request-only instance carries most scenarios; a PERIOD_CLKS=16 instance covers the timer.
module tb_status_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       enable_p;
  logic       req;
  logic       rx_beat;
  logic       rx_drop;
  logic       underrun;
  logic       fifo_empty;
  logic       fifo_full;
  logic       tx_ready_si;
  logic [7:0] tx_data_si;
  logic       tx_valid_si;
  logic       busy;
  logic [7:0] tx_data_p;
  logic       tx_valid_p;
  logic       busy_p;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_pkt [8];

  always #5 clk = ~clk;

  status_reporter #(.PERIOD_CLKS(0), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .rx_beat(rx_beat),
    .rx_drop(rx_drop), .underrun(underrun), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .tx_data_si(tx_data_si), .tx_valid_si(tx_valid_si), .tx_ready_si(tx_ready_si), .busy(busy)
  );

  status_reporter #(.PERIOD_CLKS(16), .SYNC_BYTE(8'hA5)) dut_p (
    .clk(clk), .rst(rst), .enable(enable_p), .req(req), .rx_beat(rx_beat),
    .rx_drop(rx_drop), .underrun(underrun), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .tx_data_si(tx_data_p), .tx_valid_si(tx_valid_p), .tx_ready_si(tx_ready_si), .busy(busy_p)
  );

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [7:0] s, input logic [7:0] f, input logic [7:0] rh,
                         input logic [7:0] rl, input logic [7:0] o, input logic [7:0] u,
                         input logic [7:0] c);
    exp_pkt[0] = 8'hA5; exp_pkt[1] = s;  exp_pkt[2] = f;  exp_pkt[3] = rh;
    exp_pkt[4] = rl;    exp_pkt[5] = o;  exp_pkt[6] = u;  exp_pkt[7] = c;
  endtask

  task automatic pulse_req(input string name);
    req = 1'b1;
    step();
    req = 1'b0;
    check_bit({name, " latency"}, tx_valid_si, 1'b1);
  endtask

  // Receives one packet; valid must already be up. req_mask pulses req on early cycles.
  task automatic get_packet(input string name, input bit bp, input logic [7:0] req_mask);
    int k;
    int cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      tx_ready_si = bp ? pat[cyc % 4] : 1'b1;
      req = (cyc < 8) ? req_mask[cyc] : 1'b0;
      check_bit({name, " valid"}, tx_valid_si, 1'b1);
      check_byte($sformatf("%s byte%0d", name, k), tx_data_si, exp_pkt[k]);
      if (tx_valid_si === 1'b1 && tx_ready_si === 1'b1) k++;
      step();
      cyc++;
    end
    req = 1'b0;
    tx_ready_si = 1'b1;
    check_int({name, " bytes"}, k, 8);
    check_bit({name, " valid_end"}, tx_valid_si, 1'b0);
    check_bit({name, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int starts;
    int last;
    logic prev;

    rst = 1'b1; enable = 1'b1; enable_p = 1'b0; req = 1'b0;
    rx_beat = 1'b0; rx_drop = 1'b0; underrun = 1'b0;
    fifo_empty = 1'b1; fifo_full = 1'b0; tx_ready_si = 1'b1;
    step(); step(); step();
    check_bit("rst valid", tx_valid_si, 1'b0);
    check_byte("rst data", tx_data_si, 8'h00);
    check_bit("rst busy", busy, 1'b0);
    check_bit("rst valid_p", tx_valid_p, 1'b0);
    rst = 1'b0;
    step();

    // Basic packet after three accepted bytes
    for (int i = 0; i < 3; i++) begin
      rx_beat = 1'b1; step(); rx_beat = 1'b0; step();
    end
    set_pkt(8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h02);
    pulse_req("p1");
    get_packet("p1", 1'b0, 8'h00);

    // Saturating drop counter, underruns, full flag
    fifo_empty = 1'b0; fifo_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx_drop = 1'b1;
      underrun = (i == 10 || i == 20);
      step();
    end
    rx_drop = 1'b0; underrun = 1'b0;
    step();
    set_pkt(8'h01, 8'h02, 8'h00, 8'h03, 8'hFF, 8'h02, 8'hFD);
    pulse_req("p2");
    get_packet("p2", 1'b0, 8'h00);
    set_pkt(8'h02, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03);
    pulse_req("p3");
    get_packet("p3", 1'b0, 8'h00);

    // Backpressure
    fifo_full = 1'b0; fifo_empty = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_beat = 1'b1; step(); rx_beat = 1'b0; step();
    end
    set_pkt(8'h03, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h07);
    pulse_req("bp");
    get_packet("bp", 1'b1, 8'h00);

    // Three requests mid-packet: one follow-up with missed, then a clean one
    set_pkt(8'h04, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
    pulse_req("m1");
    get_packet("m1", 1'b0, 8'b0000_1110);
    step();
    set_pkt(8'h05, 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05);
    get_packet("m2", 1'b0, 8'h00);
    step();
    check_bit("m2 no extra", tx_valid_si, 1'b0);
    set_pkt(8'h06, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h02);
    pulse_req("m3");
    get_packet("m3", 1'b0, 8'h00);

    // Periodic timer on the second instance
    enable_p = 1'b1; starts = 0; last = 0; prev = tx_valid_p;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (tx_valid_p === 1'b1 && prev !== 1'b1) begin
        starts++;
        if (starts == 1) check_int("tick first", c, 16);
        else check_int("tick spacing", c - last, 16);
        last = c;
      end
      prev = tx_valid_p;
    end
    check_int("tick starts", starts, 4);
    enable_p = 1'b0; starts = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (tx_valid_p === 1'b1 && prev !== 1'b1) starts++;
      prev = tx_valid_p;
    end
    check_int("disabled starts", starts, 0);
    check_int("disabled timer", int'(dut_p.timer), 0);
    enable_p = 1'b1; starts = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (tx_valid_p === 1'b1 && prev !== 1'b1) begin
        starts++;
        check_int("reenable first", c, 16);
      end
      prev = tx_valid_p;
    end
    check_int("reenable starts", starts, 1);
    enable_p = 1'b0;
    step();

    // Reset mid-packet
    pulse_req("r1");
    for (int i = 0; i < 4; i++) step();
    check_byte("r1 byte4", tx_data_si, 8'h05);
    rst = 1'b1;
    step();
    check_bit("r1 valid", tx_valid_si, 1'b0);
    check_bit("r1 busy", busy, 1'b0);
    check_byte("r1 data", tx_data_si, 8'h00);
    rst = 1'b0;
    set_pkt(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    pulse_req("r2");
    get_packet("r2", 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
